// File: rtl/mp5_pkg.sv
// Shared mp5 sizing constants and types used by the phantom resolver slice.
package mp5_pkg;

    localparam int NUM_PIPELINES = 4;
    localparam int NUM_STAGES    = 4;
    localparam int FIFO_SIZE     = 8;
    localparam int FIFO_ID_W     = $clog2(NUM_PIPELINES);
    localparam int ADDR_W        = $clog2(FIFO_SIZE);

    typedef struct packed {
        logic [15:0] id;
        logic        is_phantom;
        logic [15:0] data;
    } Packet;

    typedef struct packed {
        logic  valid;
        Packet pkt;
    } FIFO_Entry;

    typedef struct packed {
        Packet                pkt;
        logic [FIFO_ID_W-1:0] fifo_id;
    } Entry;

    typedef struct packed {
        logic                 valid;
        logic [15:0]          id;
        logic [FIFO_ID_W-1:0] fifo_id;
        logic [ADDR_W-1:0]    addr;
    } Map_Entry;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_RETRY  = 2'd2,
        ST_ISSUE  = 2'd3
    } Resolver_State;

    function automatic Packet clear_phantom(input Packet p);
        Packet r;
        r            = p;
        r.is_phantom = 1'b0;
        return r;
    endfunction

endpackage

// File: rtl/mp5_phantom_resolver_if.sv
// Record / real-packet / insert signal bundle between an mp5 stage and its resolver.
interface mp5_phantom_resolver_if;
    import mp5_pkg::*;

    logic                 rec_valid;
    logic [15:0]          rec_id;
    logic [FIFO_ID_W-1:0] rec_fifo_id;
    logic [ADDR_W-1:0]    rec_addr;
    logic                 rec_drop;
    logic                 real_valid;
    Packet                real_pkt;
    logic                 real_ready;
    logic                 stage_push;
    logic                 insert_valid;
    logic [FIFO_ID_W-1:0] insert_fifo_id;
    logic [ADDR_W-1:0]    insert_addr;
    Packet                insert_pkt;
    logic                 miss_drop;

    modport master (
        output rec_valid, rec_id, rec_fifo_id, rec_addr, real_valid, real_pkt, stage_push,
        input  rec_drop, real_ready, insert_valid, insert_fifo_id, insert_addr, insert_pkt, miss_drop
    );

    modport slave (
        input  rec_valid, rec_id, rec_fifo_id, rec_addr, real_valid, real_pkt, stage_push,
        output rec_drop, real_ready, insert_valid, insert_fifo_id, insert_addr, insert_pkt, miss_drop
    );

endinterface

// File: rtl/mp5_addr_map.sv
// CAM-style phantom address map: record/overwrite/allocate, id lookup and indexed free.
module mp5_addr_map import mp5_pkg::*; #(
    parameter int  MAP_DEPTH = 16,
    localparam int IDX_W     = $clog2(MAP_DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rec_valid,
    input  logic [15:0]          rec_id,
    input  logic [FIFO_ID_W-1:0] rec_fifo_id,
    input  logic [ADDR_W-1:0]    rec_addr,
    output logic                 rec_full,
    input  logic [15:0]          look_id,
    output logic                 look_hit,
    output logic [IDX_W-1:0]     look_idx,
    output logic [FIFO_ID_W-1:0] look_fifo_id,
    output logic [ADDR_W-1:0]    look_addr,
    input  logic                 free_en,
    input  logic [IDX_W-1:0]     free_idx
);

    Map_Entry             map_r [MAP_DEPTH];
    logic [MAP_DEPTH-1:0] rec_match_s;
    logic [MAP_DEPTH-1:0] look_match_s;
    logic [MAP_DEPTH-1:0] free_s;
    logic [IDX_W-1:0]     rec_idx_s;
    logic [IDX_W-1:0]     free_slot_s;

    function automatic logic [IDX_W-1:0] lowest_set(input logic [MAP_DEPTH-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = MAP_DEPTH - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = IDX_W'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // Per-entry match and free vectors for both the record and lookup sides.
    always_comb begin
        rec_match_s  = '0;
        look_match_s = '0;
        free_s       = '0;
        for (int i = 0; i < MAP_DEPTH; i++) begin
            rec_match_s[i]  = map_r[i].valid && (map_r[i].id == rec_id);
            look_match_s[i] = map_r[i].valid && (map_r[i].id == look_id);
            free_s[i]       = !map_r[i].valid;
        end
    end

    assign rec_idx_s    = lowest_set(rec_match_s);
    assign free_slot_s  = lowest_set(free_s);
    assign rec_full     = rec_valid && !(|rec_match_s) && !(|free_s);
    assign look_hit     = |look_match_s;
    assign look_idx     = lowest_set(look_match_s);
    assign look_fifo_id = map_r[look_idx].fifo_id;
    assign look_addr    = map_r[look_idx].addr;

    // Entry storage; a free on the same edge as an overwrite of that slot still clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MAP_DEPTH; i++) begin
                map_r[i] <= '0;
            end
        end else begin
            if (rec_valid && (|rec_match_s)) begin
                map_r[rec_idx_s].fifo_id <= rec_fifo_id;
                map_r[rec_idx_s].addr    <= rec_addr;
            end else if (rec_valid && (|free_s)) begin
                map_r[free_slot_s] <= '{valid: 1'b1, id: rec_id, fifo_id: rec_fifo_id, addr: rec_addr};
            end
            if (free_en) begin
                map_r[free_idx].valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mp5_phantom_resolver.sv
// Phantom resolver for one mp5 stage: maps returning real packets onto their phantom slots.
// Optional 32-bit event counters are built when MP5_RESOLVER_STATS_EN is defined.
module mp5_phantom_resolver import mp5_pkg::*; #(
    parameter int MAP_DEPTH    = 16,
    parameter int MISS_TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    mp5_phantom_resolver_if.slave bus
`ifdef MP5_RESOLVER_STATS_EN
    ,
    output logic [31:0]           stat_inserts,
    output logic [31:0]           stat_rec_drops,
    output logic [31:0]           stat_miss_drops,
    output logic [31:0]           stat_push_stalls
`endif
);

    localparam int         IDX_W       = $clog2(MAP_DEPTH);
    localparam logic [7:0] TIMEOUT_CNT = 8'(MISS_TIMEOUT);

    Resolver_State        state_r, state_s;
    Packet                held_pkt_r, ins_pkt_r;
    logic [7:0]           retry_cnt_r, retry_cnt_s;
    logic [FIFO_ID_W-1:0] ins_fifo_r;
    logic [ADDR_W-1:0]    ins_addr_r;
    logic [IDX_W-1:0]     free_idx_r;
    logic                 ins_valid_r, rec_drop_r, miss_drop_r;
    logic                 take_s, load_s, miss_s, done_s;
    logic                 rec_full_s, hit_s;
    logic [IDX_W-1:0]     hit_idx_s;
    logic [FIFO_ID_W-1:0] hit_fifo_s;
    logic [ADDR_W-1:0]    hit_addr_s;

    mp5_addr_map #(.MAP_DEPTH(MAP_DEPTH)) u_map (
        .clk          (clk),
        .rst          (rst),
        .rec_valid    (bus.rec_valid),
        .rec_id       (bus.rec_id),
        .rec_fifo_id  (bus.rec_fifo_id),
        .rec_addr     (bus.rec_addr),
        .rec_full     (rec_full_s),
        .look_id      (held_pkt_r.id),
        .look_hit     (hit_s),
        .look_idx     (hit_idx_s),
        .look_fifo_id (hit_fifo_s),
        .look_addr    (hit_addr_s),
        .free_en      (done_s),
        .free_idx     (free_idx_r)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state decode.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.real_valid) state_s = ST_LOOKUP;
                else                state_s = ST_IDLE;
            end
            ST_LOOKUP: begin
                if (hit_s) state_s = ST_ISSUE;
                else       state_s = ST_RETRY;
            end
            ST_RETRY: begin
                if (hit_s)                           state_s = ST_ISSUE;
                else if (retry_cnt_r == TIMEOUT_CNT) state_s = ST_IDLE;
                else                                 state_s = ST_RETRY;
            end
            ST_ISSUE: begin
                if (!bus.stage_push) state_s = ST_IDLE;
                else                 state_s = ST_ISSUE;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // FSM output decode: capture, hit load, retry count, timeout and insert completion.
    always_comb begin
        take_s      = 1'b0;
        load_s      = 1'b0;
        miss_s      = 1'b0;
        done_s      = 1'b0;
        retry_cnt_s = retry_cnt_r;
        case (state_r)
            ST_IDLE: begin
                take_s      = bus.real_valid;
                retry_cnt_s = 8'd0;
            end
            ST_LOOKUP: begin
                load_s = hit_s;
                if (hit_s) retry_cnt_s = 8'd0;
                else       retry_cnt_s = 8'd1;
            end
            ST_RETRY: begin
                load_s = hit_s;
                if (hit_s) begin
                    retry_cnt_s = 8'd0;
                end else if (retry_cnt_r == TIMEOUT_CNT) begin
                    miss_s      = 1'b1;
                    retry_cnt_s = 8'd0;
                end else begin
                    retry_cnt_s = retry_cnt_r + 8'd1;
                end
            end
            ST_ISSUE: begin
                done_s = !bus.stage_push;
            end
            default: begin
                retry_cnt_s = 8'd0;
            end
        endcase
    end

    // Holding register and registered insert/drop outputs; insert fields freeze once loaded.
    always_ff @(posedge clk) begin
        if (rst) begin
            held_pkt_r  <= '0;
            retry_cnt_r <= 8'd0;
            ins_valid_r <= 1'b0;
            ins_fifo_r  <= '0;
            ins_addr_r  <= '0;
            ins_pkt_r   <= '0;
            free_idx_r  <= '0;
            rec_drop_r  <= 1'b0;
            miss_drop_r <= 1'b0;
        end else begin
            if (take_s) held_pkt_r <= bus.real_pkt;
            if (load_s) begin
                ins_fifo_r <= hit_fifo_s;
                ins_addr_r <= hit_addr_s;
                ins_pkt_r  <= clear_phantom(held_pkt_r);
                free_idx_r <= hit_idx_s;
            end
            retry_cnt_r <= retry_cnt_s;
            ins_valid_r <= (state_s == ST_ISSUE);
            rec_drop_r  <= rec_full_s;
            miss_drop_r <= miss_s;
        end
    end

    assign bus.real_ready     = (state_r == ST_IDLE);
    assign bus.insert_valid   = ins_valid_r;
    assign bus.insert_fifo_id = ins_fifo_r;
    assign bus.insert_addr    = ins_addr_r;
    assign bus.insert_pkt     = ins_pkt_r;
    assign bus.rec_drop       = rec_drop_r;
    assign bus.miss_drop      = miss_drop_r;

`ifdef MP5_RESOLVER_STATS_EN
    // Wrapping event counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_inserts     <= 32'd0;
            stat_rec_drops   <= 32'd0;
            stat_miss_drops  <= 32'd0;
            stat_push_stalls <= 32'd0;
        end else begin
            if (done_s)     stat_inserts    <= stat_inserts + 32'd1;
            if (rec_full_s) stat_rec_drops  <= stat_rec_drops + 32'd1;
            if (miss_s)     stat_miss_drops <= stat_miss_drops + 32'd1;
            if ((state_r == ST_ISSUE) && bus.stage_push) stat_push_stalls <= stat_push_stalls + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mp5_phantom_resolver.sv
// Directed bench for mp5_phantom_resolver; inputs driven and outputs sampled on the falling edge.
module tb_mp5_phantom_resolver;
    import mp5_pkg::*;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    mp5_phantom_resolver_if bus ();

`ifdef MP5_RESOLVER_STATS_EN
    logic [31:0] s_ins, s_rd, s_md, s_ps;
`endif

    mp5_phantom_resolver #(.MAP_DEPTH(16), .MISS_TIMEOUT(15)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
`ifdef MP5_RESOLVER_STATS_EN
        ,
        .stat_inserts     (s_ins),
        .stat_rec_drops   (s_rd),
        .stat_miss_drops  (s_md),
        .stat_push_stalls (s_ps)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (bus.real_ready !== 1'b1) begin
            n_bad++; $display("FAIL reset_real_ready got=%b want=1", bus.real_ready);
        end
        n_cmp++;
        if ({bus.insert_valid, bus.rec_drop, bus.miss_drop} !== 3'b000) begin
            n_bad++; $display("FAIL reset_pulses got=%b want=000", {bus.insert_valid, bus.rec_drop, bus.miss_drop});
        end
        n_cmp++;
        if ({bus.insert_fifo_id, bus.insert_addr, bus.insert_pkt} !== '0) begin
            n_bad++; $display("FAIL reset_insert_fields got=%h/%h/%h want=0", bus.insert_fifo_id, bus.insert_addr, bus.insert_pkt);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic_resolve();
        Packet exp;
        exp = '{id: 16'h0042, is_phantom: 1'b0, data: 16'hBEEF};
        @(negedge clk); // cycle 0
        bus.rec_valid = 1'b1; bus.rec_id = 16'h0042; bus.rec_fifo_id = 2'd2; bus.rec_addr = 3'd5;
        @(negedge clk); // cycle 1
        bus.rec_valid = 1'b0;
        n_cmp++;
        if (bus.rec_drop !== 1'b0) begin
            n_bad++; $display("FAIL basic_rec_drop got=%b want=0", bus.rec_drop);
        end
        repeat (2) @(negedge clk); // cycle 3
        n_cmp++;
        if (bus.real_ready !== 1'b1) begin
            n_bad++; $display("FAIL basic_ready_idle got=%b want=1", bus.real_ready);
        end
        bus.real_valid = 1'b1; bus.real_pkt = '{id: 16'h0042, is_phantom: 1'b1, data: 16'hBEEF};
        @(negedge clk); // cycle 4: LOOKUP
        bus.real_valid = 1'b0;
        n_cmp++;
        if ({bus.real_ready, bus.insert_valid} !== 2'b00) begin
            n_bad++; $display("FAIL basic_lookup ready/valid got=%b want=00", {bus.real_ready, bus.insert_valid});
        end
        @(negedge clk); // cycle 5: ISSUE
        n_cmp++;
        if ({bus.insert_valid, bus.insert_fifo_id, bus.insert_addr} !== {1'b1, 2'd2, 3'd5}) begin
            n_bad++; $display("FAIL basic_insert v/fifo/addr got=%b/%0d/%0d want=1/2/5", bus.insert_valid, bus.insert_fifo_id, bus.insert_addr);
        end
        n_cmp++;
        if (bus.insert_pkt !== exp) begin
            n_bad++; $display("FAIL basic_insert_pkt got=%h want=%h", bus.insert_pkt, exp);
        end
        @(negedge clk); // cycle 6
        n_cmp++;
        if ({bus.insert_valid, bus.real_ready} !== 2'b01) begin
            n_bad++; $display("FAIL basic_done valid/ready got=%b want=01", {bus.insert_valid, bus.real_ready});
        end
    endtask

    task automatic test_timeout(input logic [15:0] id);
        @(negedge clk);
        n_cmp++;
        if (bus.real_ready !== 1'b1) begin
            n_bad++; $display("FAIL timeout_ready id=%h got=%b want=1", id, bus.real_ready);
        end
        bus.real_valid = 1'b1; bus.real_pkt = '{id: id, is_phantom: 1'b1, data: 16'h1234};
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            bus.real_valid = 1'b0;
            n_cmp++;
            if ({bus.miss_drop, bus.insert_valid, bus.real_ready} !== 3'b000) begin
                n_bad++; $display("FAIL timeout_wait id=%h cyc=%0d drop/valid/ready got=%b want=000", id, k, {bus.miss_drop, bus.insert_valid, bus.real_ready});
            end
        end
        @(negedge clk);
        n_cmp++;
        if ({bus.miss_drop, bus.real_ready} !== 2'b11) begin
            n_bad++; $display("FAIL timeout_drop id=%h drop/ready got=%b want=11", id, {bus.miss_drop, bus.real_ready});
        end
        @(negedge clk);
        n_cmp++;
        if (bus.miss_drop !== 1'b0) begin
            n_bad++; $display("FAIL timeout_single_pulse id=%h got=%b want=0", id, bus.miss_drop);
        end
    endtask

    task automatic test_push_collision();
        @(negedge clk);
        bus.rec_valid = 1'b1; bus.rec_id = 16'h0011; bus.rec_fifo_id = 2'd1; bus.rec_addr = 3'd3;
        @(negedge clk);
        bus.rec_valid = 1'b0;
        @(negedge clk); // T
        bus.real_valid = 1'b1; bus.real_pkt = '{id: 16'h0011, is_phantom: 1'b1, data: 16'h5A5A};
        @(negedge clk); // T+1
        bus.real_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); // T+2 .. T+5
            n_cmp++;
            if ({bus.insert_valid, bus.insert_fifo_id, bus.insert_addr, bus.insert_pkt} !==
                {1'b1, 2'd1, 3'd3, 16'h0011, 1'b0, 16'h5A5A}) begin
                n_bad++; $display("FAIL push_hold cyc=%0d got=%b/%0d/%0d/%h want=1/1/3/0011_0_5a5a", k, bus.insert_valid, bus.insert_fifo_id, bus.insert_addr, bus.insert_pkt);
            end
            bus.stage_push = (k < 3) ? 1'b1 : 1'b0;
        end
        @(negedge clk); // T+6
        n_cmp++;
        if ({bus.insert_valid, bus.real_ready} !== 2'b01) begin
            n_bad++; $display("FAIL push_done valid/ready got=%b want=01", {bus.insert_valid, bus.real_ready});
        end
    endtask

    task automatic test_early_real();
        @(negedge clk); // T
        bus.real_valid = 1'b1; bus.real_pkt = '{id: 16'h0007, is_phantom: 1'b1, data: 16'h0777};
        @(negedge clk); // T+1
        bus.real_valid = 1'b0;
        repeat (3) @(negedge clk); // T+4
        bus.rec_valid = 1'b1; bus.rec_id = 16'h0007; bus.rec_fifo_id = 2'd3; bus.rec_addr = 3'd6;
        @(negedge clk); // T+5
        bus.rec_valid = 1'b0;
        n_cmp++;
        if (bus.insert_valid !== 1'b0) begin
            n_bad++; $display("FAIL early_not_yet got=%b want=0", bus.insert_valid);
        end
        @(negedge clk); // T+6
        n_cmp++;
        if ({bus.insert_valid, bus.insert_fifo_id, bus.insert_addr, bus.miss_drop} !== {1'b1, 2'd3, 3'd6, 1'b0}) begin
            n_bad++; $display("FAIL early_insert v/fifo/addr/drop got=%b/%0d/%0d/%b want=1/3/6/0", bus.insert_valid, bus.insert_fifo_id, bus.insert_addr, bus.miss_drop);
        end
        @(negedge clk); // T+7
        n_cmp++;
        if ({bus.insert_valid, bus.miss_drop, bus.real_ready} !== 3'b001) begin
            n_bad++; $display("FAIL early_done valid/drop/ready got=%b want=001", {bus.insert_valid, bus.miss_drop, bus.real_ready});
        end
    endtask

    task automatic test_map_full();
        logic [15:0] id;
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            if (i > 0) begin
                n_cmp++;
                if (bus.rec_drop !== 1'b0) begin
                    n_bad++; $display("FAIL full_fill_drop rec=%0d got=%b want=0", i - 1, bus.rec_drop);
                end
            end
            id = (i < 16) ? 16'(i) : 16'h0020;
            bus.rec_valid = 1'b1; bus.rec_id = id; bus.rec_fifo_id = id[1:0]; bus.rec_addr = id[2:0];
        end
        @(negedge clk);
        n_cmp++;
        if (bus.rec_drop !== 1'b1) begin
            n_bad++; $display("FAIL full_17th_drop got=%b want=1", bus.rec_drop);
        end
        bus.rec_id = 16'h0003; bus.rec_fifo_id = 2'd1; bus.rec_addr = 3'd7;
        @(negedge clk);
        bus.rec_valid = 1'b0;
        n_cmp++;
        if (bus.rec_drop !== 1'b0) begin
            n_bad++; $display("FAIL full_overwrite_drop got=%b want=0", bus.rec_drop);
        end
        @(negedge clk); // T
        bus.real_valid = 1'b1; bus.real_pkt = '{id: 16'h0003, is_phantom: 1'b1, data: 16'h0303};
        @(negedge clk);
        bus.real_valid = 1'b0;
        @(negedge clk); // T+2
        n_cmp++;
        if ({bus.insert_valid, bus.insert_fifo_id, bus.insert_addr} !== {1'b1, 2'd1, 3'd7}) begin
            n_bad++; $display("FAIL full_overwrite_insert v/fifo/addr got=%b/%0d/%0d want=1/1/7", bus.insert_valid, bus.insert_fifo_id, bus.insert_addr);
        end
        @(negedge clk);
        n_cmp++;
        if ({bus.insert_valid, bus.real_ready} !== 2'b01) begin
            n_bad++; $display("FAIL full_overwrite_done valid/ready got=%b want=01", {bus.insert_valid, bus.real_ready});
        end
    endtask

    task automatic test_reset_mid_issue();
        @(negedge clk); // T: id 5 still mapped to fifo 1, addr 5
        bus.real_valid = 1'b1; bus.real_pkt = '{id: 16'h0005, is_phantom: 1'b1, data: 16'h0505};
        @(negedge clk);
        bus.real_valid = 1'b0;
        @(negedge clk); // T+2
        n_cmp++;
        if ({bus.insert_valid, bus.insert_fifo_id, bus.insert_addr} !== {1'b1, 2'd1, 3'd5}) begin
            n_bad++; $display("FAIL rst_issue_setup v/fifo/addr got=%b/%0d/%0d want=1/1/5", bus.insert_valid, bus.insert_fifo_id, bus.insert_addr);
        end
        rst = 1'b1; bus.stage_push = 1'b1;
        @(negedge clk); // T+3
        rst = 1'b0; bus.stage_push = 1'b0;
        n_cmp++;
        if ({bus.insert_valid, bus.real_ready, bus.insert_addr} !== {1'b0, 1'b1, 3'd0}) begin
            n_bad++; $display("FAIL rst_issue_abandon valid/ready/addr got=%b/%b/%0d want=0/1/0", bus.insert_valid, bus.real_ready, bus.insert_addr);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        bus.rec_valid = 1'b0; bus.rec_id = 16'h0000; bus.rec_fifo_id = 2'd0; bus.rec_addr = 3'd0;
        bus.real_valid = 1'b0; bus.real_pkt = '0; bus.stage_push = 1'b0;
        test_reset();
        test_basic_resolve();
        test_timeout(16'h0042);
        test_push_collision();
        test_early_real();
        test_timeout(16'h0099);
        test_map_full();
        test_reset_mid_issue();
        test_timeout(16'h0005);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mp5_phantom_resolver.md
Name: mp5_phantom_resolver

Overview:
- Responder side of the phantom-packet push/insert interface of an mp5 stage.
- Records each phantom's (id, fifo_id, FIFO address) reported by the stage into a small CAM-style address map.
- When the matching real packet returns, looks up its id and drives an insert that overwrites the phantom slot in place, then frees the map entry.
- One instance sits beside each mp5 stage.

Parameters:
- NUM_PIPELINES, 4: number of pipelines/FIFOs per stage; power of 2, at least 2.
- FIFO_SIZE, 8: stage FIFO depth; power of 2.
- MAP_DEPTH, 16: address-map entries; power of 2.
- MISS_TIMEOUT, 15: retry cycles allowed for a real packet whose record has not yet arrived; 1..255.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rec_valid  in  1  stage reports a phantom push this cycle
- rec_id  in  16  phantom id
- rec_fifo_id  in  $clog2(NUM_PIPELINES)  FIFO holding the phantom
- rec_addr  in  $clog2(FIFO_SIZE)  slot address of the phantom
- rec_drop  out  1  one-cycle pulse: record lost because the map is full
- real_valid  in  1  real (resolved) packet offered
- real_pkt  in  Packet  real packet; id matches its phantom
- real_ready  out  1  resolver accepts real_pkt
- stage_push  in  1  mirror of the stage's push_in; a push wins over an insert
- insert_valid  out  1  to stage insert_in
- insert_fifo_id  out  $clog2(NUM_PIPELINES)  to stage fifo_id_in during the insert
- insert_addr  out  $clog2(FIFO_SIZE)  to stage addr_in
- insert_pkt  out  Packet  packet to write; is_phantom forced to 0
- miss_drop  out  1  one-cycle pulse: real packet discarded after timeout

Behaviour:
- Reset values:
  - All map valid bits = 0.
  - FSM state = IDLE.
  - real_ready = 1.
  - insert_valid, rec_drop, miss_drop = 0.
  - insert_fifo_id, insert_addr, insert_pkt = 0.
  - Retry counter = 0.
- Reset mid-operation: any in-flight insert is abandoned; the captured packet is discarded silently.
- Record path (independent of the FSM):
  - When rec_valid=1, if an entry with a valid, equal id exists, overwrite its fifo_id and addr.
  - Otherwise write the lowest-index free entry.
  - Otherwise pulse rec_drop the next cycle; the map is unchanged.
  - Writes become visible to lookups on the following cycle.
- Real-packet handshake: transfer occurs when real_valid & real_ready. real_ready = (state == IDLE). The packet is captured into a holding register.
- FSM states:
  - IDLE: on transfer, go to LOOKUP.
  - LOOKUP: match the held id against all valid entries.
    - Hit: register fifo_id and addr, go to ISSUE.
    - Miss: set retry count = 1, go to RETRY.
  - RETRY: re-match each cycle.
    - Hit: go to ISSUE.
    - Miss and count == MISS_TIMEOUT: pulse miss_drop, go to IDLE.
    - Miss otherwise: increment count.
  - ISSUE:
    - insert_valid = 1, with insert_fifo_id, insert_addr and insert_pkt held stable.
    - Insert completes in any ISSUE cycle with stage_push == 0. On that edge the map entry is invalidated and the FSM goes to IDLE.
    - While stage_push == 1, stay in ISSUE and keep all outputs stable.
- Latency:
  - Transfer at cycle T: LOOKUP at T+1, insert_valid first high at T+2.
  - With stage_push = 0: insert done at T+2, entry freed and real_ready = 1 at T+3.
- Simultaneous events:
  - Record and free on the same edge: both apply. The freed slot is not allocatable until the next cycle.
  - Record for an id currently in ISSUE: the overwrite applies, but the in-flight insert keeps its registered address.
  - Duplicate hits are impossible by construction (overwrite rule).
- Outputs are registered except real_ready, which is decoded from state.

Optional Feature:
- Macro: MP5_RESOLVER_STATS_EN.
- When defined, the block adds 32-bit wrapping counters, all clearing on rst:
  - stat_inserts
  - stat_rec_drops
  - stat_miss_drops
  - stat_push_stalls (ISSUE cycles with stage_push = 1)
- The counters are exposed as output ports.
- When undefined, the counters and ports are absent and behaviour is otherwise identical.

Decomposition:
- mp5_pkg holds:
  - NUM_PIPELINES, NUM_STAGES, FIFO_SIZE.
  - The Packet, FIFO_Entry and Entry typedefs.
  - A new Map_Entry typedef: valid, id[15:0], fifo_id, addr.
- Sub-module mp5_addr_map provides:
  - Entry storage.
  - Record/overwrite/allocate logic.
  - The combinational id match with hit flag and index.
  - An index-addressed free port.
- The FSM, holding register and insert outputs stay in mp5_phantom_resolver.

Test Plan:
- Basic resolve: record id=0x0042 fifo=2 addr=5 at cycle 0; real id=0x0042 at cycle 3 -> insert_valid at cycle 5 with fifo_id=2, addr=5, is_phantom=0; entry freed at cycle 6.
- Push collision: set up a hit, hold stage_push=1 for 3 cycles during ISSUE -> insert_valid high for 4 cycles with outputs stable; completes on the first cycle with stage_push = 0.
- Early real packet: real id=0x0007 with no record; record arrives 4 cycles later -> hit in RETRY, insert issued with the recorded address, no miss_drop.
- Timeout: real id=0x0099 never recorded, MISS_TIMEOUT=15 -> miss_drop pulses once about 16 cycles after LOOKUP; real_ready returns to 1 the next cycle.
- Map full: 16 distinct records, then a 17th -> rec_drop pulses. Re-record id=0x0003 with addr=7 -> overwrite, no rec_drop, later insert uses addr=7.
- Reset mid-ISSUE: assert rst while insert_valid=1 -> next cycle insert_valid=0, real_ready=1, map empty; a subsequent lookup misses.
